// File: rtl/sha256d_nonce_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256_pkg                                                      |
// | Purpose  : Shared SHA-256 types, constants and round helper functions.     |
// |            Also holds the sweep FSM state type.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:7] state_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_RND1  = 3'd2,
    ST_LOAD2 = 3'd3,
    ST_RND2  = 3'd4,
    ST_OUT   = 3'd5
  } fsm_t;

  localparam word_t PAD_WORD = 32'h8000_0000;
  localparam word_t LEN_PASS1 = 32'd640;  // 80-byte block header
  localparam word_t LEN_PASS2 = 32'd256;  // 32-byte first digest

  localparam word_t [0:63] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule sigmas
  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression-round sigmas
  function automatic word_t Sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t Sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256d_nonce_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256d_nonce_engine_if                                         |
// | Purpose  : Host-side bus of the nonce engine.                              |
// |            master: register bank (drives job, reads results)               |
// |            slave : engine                                                  |
// |            job   : start, abort, midstate, tail, nonce_base, num_batches,  |
// |                    target_h0                                               |
// |            result: busy, res_valid, res_nonce_base, res_h0, found,         |
// |                    found_nonce, done                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sha256d_nonce_engine_if #(
  parameter int NUM_LANES = 16,
  parameter int BATCH_W   = 16
);
  import sha256_pkg::*;

  logic                      start;
  logic                      abort;
  state_t                    midstate;
  word_t [0:2]               tail;
  word_t                     nonce_base;
  logic [BATCH_W-1:0]        num_batches;
  word_t                     target_h0;

  logic                      busy;
  logic                      res_valid;
  word_t                     res_nonce_base;
  word_t [0:NUM_LANES-1]     res_h0;
  logic                      found;
  word_t                     found_nonce;
  logic                      done;

  modport master (
    output start, abort, midstate, tail, nonce_base, num_batches, target_h0,
    input  busy, res_valid, res_nonce_base, res_h0, found, found_nonce, done
  );

  modport slave (
    input  start, abort, midstate, tail, nonce_base, num_batches, target_h0,
    output busy, res_valid, res_nonce_base, res_h0, found, found_nonce, done
  );

endinterface
`default_nettype wire

// File: rtl/sha256d_nonce_engine_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256_lane                                                     |
// | Purpose  : One SHA-256d lane: working vars A..H, chaining h[0:7] and a     |
// |            16-word message window that shifts left each round.             |
// | Ports    : clk       clock                                                 |
// |            load1     load pass-1 block (midstate, tail, nonce)             |
// |            load2     load pass-2 block from the pass-1 digest              |
// |            round     execute one compression round with k_in               |
// |            k_in      round constant shared by all lanes                    |
// |            nonce_in  nonce of this lane                                    |
// |            midstate  latched block-0 state                                 |
// |            tail      latched header words 16..18                           |
// |            h0_final  h[0] + A as it will be after the current round        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sha256_lane
  import sha256_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        load1,
  input  wire logic        load2,
  input  wire logic        round,
  input  wire word_t       k_in,
  input  wire word_t       nonce_in,
  input  wire state_t      midstate,
  input  wire word_t [0:2] tail,
  output word_t            h0_final
);

  // Datapath state is fully rewritten by load1 before use, so no reset.
  state_t       r_v;
  state_t       r_h;
  word_t [0:15] r_w;

  word_t  w_t1;
  word_t  w_t2;
  word_t  w_w16;
  state_t w_digest;

  always_comb begin
    w_t1  = r_v[7] + Sigma1(r_v[4]) + ch(r_v[4], r_v[5], r_v[6]) + k_in + r_w[0];
    w_t2  = Sigma0(r_v[0]) + maj(r_v[0], r_v[1], r_v[2]);
    // Next schedule word; harmlessly computed past round 63.
    w_w16 = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];
    for (int i = 0; i < 8; i++) begin
      w_digest[i] = r_h[i] + r_v[i];
    end
  end

  // Lookahead so the top can register the result on the last round edge.
  assign h0_final = r_h[0] + w_t1 + w_t2;

  always_ff @(posedge clk) begin
    if (load1) begin
      r_v <= midstate;
      r_h <= midstate;
      r_w <= {tail, nonce_in, PAD_WORD, 320'd0, LEN_PASS1};
    end else if (load2) begin
      r_v <= IV;
      r_h <= IV;
      r_w <= {w_digest, PAD_WORD, 192'd0, LEN_PASS2};
    end else if (round) begin
      r_v <= {w_t1 + w_t2, r_v[0], r_v[1], r_v[2],
              r_v[3] + w_t1, r_v[4], r_v[5], r_v[6]};
      r_w <= {r_w[1:15], w_w16};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256d_nonce_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256d_nonce_engine                                            |
// | Purpose  : Parallel SHA-256d nonce sweep. Each batch hashes NUM_LANES      |
// |            consecutive nonces in 131 cycles, reports every lane's final    |
// |            H0 and flags the first nonce whose H0 is below target_h0.       |
// | Ports    : clk      clock                                                  |
// |            reset_n  asynchronous active-low reset                          |
// |            bus      engine side (slave) of sha256d_nonce_engine_if         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sha256d_nonce_engine
  import sha256_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int BATCH_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  sha256d_nonce_engine_if.slave  bus
);

  fsm_t               r_state;
  fsm_t               w_next;
  logic [5:0]         r_round;
  logic [BATCH_W-1:0] r_batch_cnt;
  logic [BATCH_W-1:0] r_num_batches;
  word_t              r_batch_base;
  state_t             r_midstate;
  word_t [0:2]        r_tail;
  word_t              r_target;

  logic                  r_res_valid;
  word_t                 r_res_nonce_base;
  word_t [0:NUM_LANES-1] r_res_h0;
  logic                  r_found;
  word_t                 r_found_nonce;

  logic                  w_load1;
  logic                  w_load2;
  logic                  w_round;
  logic                  w_done;
  logic                  w_last_round;
  logic                  w_more;
  logic                  w_accept;
  logic                  w_batch_end;
  word_t                 w_k;
  word_t [0:NUM_LANES-1] w_h0;
  logic                  w_hit_any;
  word_t                 w_hit_lane;

  assign w_accept     = (r_state == ST_IDLE) && bus.start;
  assign w_last_round = (r_round == 6'd63);
  assign w_more       = (r_batch_cnt != r_num_batches);
  assign w_k          = K[r_round];
  // Batch completes on the last pass-2 round edge unless aborted there.
  assign w_batch_end  = (r_state == ST_RND2) && w_last_round && !bus.abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load1 = 1'b0;
    w_load2 = 1'b0;
    w_round = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Zero batches detours through OUT so done pulses one cycle later.
        if (bus.start) w_next = (bus.num_batches == '0) ? ST_OUT : ST_LOAD1;
      end
      ST_LOAD1: begin
        w_load1 = 1'b1;
        w_next  = ST_RND1;
      end
      ST_RND1: begin
        w_round = 1'b1;
        if (w_last_round) w_next = ST_LOAD2;
      end
      ST_LOAD2: begin
        w_load2 = 1'b1;
        w_next  = ST_RND2;
      end
      ST_RND2: begin
        w_round = 1'b1;
        if (w_last_round) w_next = ST_OUT;
      end
      ST_OUT: begin
        if (w_more) begin
          w_next = ST_LOAD1;
        end else begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_next = ST_IDLE;
      w_done = 1'b1;
    end
  end

  // Lowest lane index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_h0[i] < r_target) begin
        w_hit_any  = 1'b1;
        w_hit_lane = word_t'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_round          <= '0;
      r_batch_cnt      <= '0;
      r_num_batches    <= '0;
      r_batch_base     <= '0;
      r_midstate       <= '0;
      r_tail           <= '0;
      r_target         <= '0;
      r_res_valid      <= 1'b0;
      r_res_nonce_base <= '0;
      r_res_h0         <= '0;
      r_found          <= 1'b0;
      r_found_nonce    <= '0;
    end else begin
      r_res_valid <= 1'b0;
      r_round     <= w_round ? r_round + 6'd1 : 6'd0;

      if (w_accept) begin
        r_num_batches <= bus.num_batches;
        r_batch_base  <= bus.nonce_base;
        r_midstate    <= bus.midstate;
        r_tail        <= bus.tail;
        r_target      <= bus.target_h0;
        r_batch_cnt   <= '0;
        r_found       <= 1'b0;
        r_found_nonce <= '0;
      end

      if (w_batch_end) begin
        r_res_valid      <= 1'b1;
        r_res_nonce_base <= r_batch_base;
        r_res_h0         <= w_h0;
        r_batch_cnt      <= r_batch_cnt + BATCH_W'(1);
        if (!r_found && w_hit_any) begin
          r_found       <= 1'b1;
          r_found_nonce <= r_batch_base + w_hit_lane;
        end
      end

      if ((r_state == ST_OUT) && w_more && !bus.abort) begin
        r_batch_base <= r_batch_base + word_t'(NUM_LANES);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    sha256_lane u_lane (
      .clk      (clk),
      .load1    (w_load1),
      .load2    (w_load2),
      .round    (w_round),
      .k_in     (w_k),
      .nonce_in (r_batch_base + word_t'(gi)),
      .midstate (r_midstate),
      .tail     (r_tail),
      .h0_final (w_h0[gi])
    );
  end

  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.done           = w_done;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_nonce_base = r_res_nonce_base;
  assign bus.res_h0         = r_res_h0;
  assign bus.found          = r_found;
  assign bus.found_nonce    = r_found_nonce;

endmodule
`default_nettype wire

// File: tb/tb_sha256d_nonce_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sha256d_nonce_engine                                         |
// | Purpose  : Randomized self-checking bench for sha256d_nonce_engine with a  |
// |            plain SHA-256 reference model and a cycle timeline model.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sha256d_nonce_engine;
  import sha256_pkg::*;

  localparam int NL = 4;
  localparam int BW = 16;

  typedef word_t [0:15] block_t;
  typedef word_t [0:2]  tail_t;

  localparam logic [31:0] MK [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam state_t MIV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sha256d_nonce_engine_if #(.NUM_LANES(NL), .BATCH_W(BW)) bus ();

  sha256d_nonce_engine #(.NUM_LANES(NL), .BATCH_W(BW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model: textbook SHA-256 ----------------
  function automatic word_t ror(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic state_t compress(input state_t hin, input block_t blk);
    word_t w [0:63];
    word_t a, b, c, d, e, f, g, h, t1, t2;
    state_t hout;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + MK[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
    hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + h;
    return hout;
  endfunction

  function automatic word_t model_h0(input state_t mid, input tail_t tl, input word_t nonce);
    block_t b1, b2;
    state_t d1, d2;
    b1 = {tl, nonce, 32'h8000_0000, 320'd0, 32'd640};
    d1 = compress(mid, b1);
    b2 = {d1, 32'h8000_0000, 192'd0, 32'd256};
    d2 = compress(MIV, b2);
    return d2[0];
  endfunction

  // ---------------- scenario runner ----------------
  // Cycle 0 is the cycle in which the accepted start is presented.
  task automatic run(input string tag, input int nb, input word_t base, input word_t tgt,
                     input int abort_at, input int restart_at, input int noise_a,
                     input int noise_b, input int ncyc);
    state_t mid;
    tail_t  tl;
    bit     exp_rv [1024];
    bit     exp_dn [1024];
    bit     exp_bz [1024];
    word_t  exp_nb [1024];
    int     starts [$];
    int     busy_err = 0;
    bit     efound = 1'b0;
    word_t  efn = '0;
    word_t  h;

    for (int i = 0; i < 8; i++) mid[i] = $urandom();
    for (int i = 0; i < 3; i++) tl[i] = $urandom();

    starts.push_back(0);
    if (restart_at >= 0) starts.push_back(restart_at);
    foreach (starts[j]) begin
      int s = starts[j];
      int endc = s + 1;
      if (nb != 0) begin
        for (int k = 0; k < nb; k++) begin
          int c = s + 131 * (k + 1);
          if (abort_at > s && abort_at < c) begin
            endc = abort_at;
            break;
          end
          exp_rv[c] = 1'b1;
          exp_nb[c] = base + word_t'(NL * k);
          endc = c;
        end
      end
      if (abort_at > s && abort_at < endc) endc = abort_at;
      exp_dn[endc] = 1'b1;
      for (int c = s + 1; c <= endc; c++) exp_bz[c] = 1'b1;
    end

    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 0 || c == restart_at || c == noise_a || c == noise_b);
      bus.abort = (c == abort_at);
      if (c == 0 || c == restart_at) begin
        bus.midstate    = mid;
        bus.tail        = tl;
        bus.nonce_base  = base;
        bus.num_batches = BW'(nb);
        bus.target_h0   = tgt;
        efound          = 1'b0;
      end else if (c == 2) begin
        for (int i = 0; i < 8; i++) bus.midstate[i] = $urandom();
        for (int i = 0; i < 3; i++) bus.tail[i] = $urandom();
        bus.nonce_base  = $urandom();
        bus.num_batches = BW'($urandom_range(1, 5));
        bus.target_h0   = $urandom();
      end
      #2;
      if (bus.busy !== exp_bz[c]) busy_err++;
      if (bus.res_valid || exp_rv[c]) begin
        check($sformatf("%s:res_valid@%0d", tag, c), 64'(bus.res_valid), 64'(exp_rv[c]));
        if (exp_rv[c]) begin
          check($sformatf("%s:res_nonce_base@%0d", tag, c), 64'(bus.res_nonce_base), 64'(exp_nb[c]));
          for (int l = 0; l < NL; l++) begin
            h = model_h0(mid, tl, exp_nb[c] + word_t'(l));
            check($sformatf("%s:res_h0[%0d]@%0d", tag, l, c), 64'(bus.res_h0[l]), 64'(h));
            if (!efound && h < tgt) begin
              efound = 1'b1;
              efn    = exp_nb[c] + word_t'(l);
            end
          end
          check($sformatf("%s:found@%0d", tag, c), 64'(bus.found), 64'(efound));
          if (efound)
            check($sformatf("%s:found_nonce@%0d", tag, c), 64'(bus.found_nonce), 64'(efn));
        end
      end
      if (bus.done || exp_dn[c])
        check($sformatf("%s:done@%0d", tag, c), 64'(bus.done), 64'(exp_dn[c]));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check({tag, ":busy_cycle_errs"}, 64'(busy_err), 64'd0);
  endtask

  task automatic run_reset();
    int pulses = 0;
    for (int c = 0; c <= 70; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 0);
      if (c == 0) begin
        for (int i = 0; i < 8; i++) bus.midstate[i] = $urandom();
        bus.num_batches = BW'(1);
        bus.nonce_base  = $urandom();
      end
      if (c == 70) reset_n = 1'b0;
    end
    #1;
    check("rst:ctrl", 64'({bus.busy, bus.res_valid, bus.done, bus.found}), 64'd0);
    check("rst:found_nonce", 64'(bus.found_nonce), 64'd0);
    check("rst:res_nonce_base", 64'(bus.res_nonce_base), 64'd0);
    check("rst:res_h0_any", 64'(|bus.res_h0), 64'd0);
    for (int c = 71; c <= 220; c++) begin
      @(posedge clk);
      #1;
      if (c == 73) reset_n = 1'b1;
      #2;
      if (bus.done || bus.res_valid || bus.busy) pulses++;
    end
    check("rst:no_activity_after", 64'(pulses), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.midstate    = '0;
    bus.tail        = '0;
    bus.nonce_base  = '0;
    bus.num_batches = '0;
    bus.target_h0   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:ctrl", 64'({bus.busy, bus.res_valid, bus.done, bus.found}), 64'd0);
    check("reset:res_nonce_base", 64'(bus.res_nonce_base), 64'd0);
    check("reset:found_nonce", 64'(bus.found_nonce), 64'd0);
    check("reset:res_h0_any", 64'(|bus.res_h0), 64'd0);
    reset_n = 1'b1;

    //   tag       nb  base            target          abort restart noiseA noiseB ncyc
    run("timing",  1,  32'h0,          32'h0,          -1,   -1,     -1,    -1,    135);
    run("wrap",    2,  32'hFFFF_FFFE,  $urandom(),     -1,   -1,     -1,    -1,    265);
    run("found",   2,  $urandom(),     32'hFFFF_FFFF,  -1,   -1,     -1,    -1,    265);
    run("nohit",   3,  $urandom(),     32'h0,          -1,   -1,     -1,    -1,    395);
    run("abort",   1,  $urandom(),     32'hFFFF_FFFF,  100,  105,    -1,    -1,    240);
    run("zero",    0,  $urandom(),     $urandom(),     5,    -1,     -1,    -1,    8);
    run("noise",   1,  $urandom(),     $urandom(),     -1,   -1,     40,    131,   135);
    run("rand0",   2,  $urandom(),     $urandom() >> 1, -1,  -1,     -1,    -1,    265);
    run("rand1",   2,  $urandom(),     $urandom() >> 2, -1,  -1,     -1,    -1,    265);
    run_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
